sync_fifo_lvl: RTL and testbench
================================

# sync_fifo_lvl

Parametrised single-clock FIFO with fill-level output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a selectable read mode (first-word-fall-through or registered). It replaces the fixed-depth FIFO in the AXI-to-SPI path as the TX/RX data buffer between the AXI register slave and the SPI shift engine.

## Interface
- G_WIDTH, 32: data word width, ≥1.
- G_DEPTH, 16: number of entries; power of two, ≥2.
- G_AFULL, G_DEPTH-2: afull_o asserted when level ≥ G_AFULL; range 1..G_DEPTH.
- G_AEMPTY, 1: aempty_o asserted when level ≤ G_AEMPTY; range 0..G_DEPTH-1.
- G_FWFT, 1: 1 = show-ahead read (data_o combinational from head); 0 = registered read, one-cycle latency.
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clr_i  in  1  synchronous flush; same effect as rst_i on pointers, level and flags, except data_o is not cleared.
- data_i  in  G_WIDTH  write data.
- push_i  in  1  write request.
- pull_i  in  1  read request.
- data_o  out  G_WIDTH  read data.
- valid_o  out  1  data_o qualifier.
- full_o, empty_o, afull_o, aempty_o  out  1 each  status flags.
- level_o  out  clog2(G_DEPTH)+1  current entry count, 0..G_DEPTH.
- ovf_o, udf_o  out  1 each  sticky overflow / underflow error flags.

## Operation
- Read acceptance: pull_acc = pull_i & !empty_o.
- Write acceptance: push_acc = push_i & (!full_o | pull_acc). When full, a simultaneous accepted pull frees one slot, so the push is also accepted.
- Pointers:
  - wr_ptr and rd_ptr are clog2(G_DEPTH) bits wide and wrap modulo G_DEPTH with no special case.
  - wr_ptr increments on push_acc; rd_ptr increments on pull_acc.
- Level:
  - level_o is a registered counter: +1 on push_acc only, −1 on pull_acc only, unchanged when both or neither.
- Flags are combinational from level_o:
  - empty_o = (level == 0).
  - full_o = (level == G_DEPTH).
  - afull_o = (level ≥ G_AFULL).
  - aempty_o = (level ≤ G_AEMPTY).
- Error flags:
  - ovf_o sets on push_i & !push_acc; udf_o sets on pull_i & !pull_acc.
  - Both hold until rst_i or clr_i; rejected requests change no other state.
- Simultaneous push and pull when empty: the pull is rejected (udf_o set) and the push is accepted; level becomes 1.
- Memory:
  - Written at wr_ptr on push_acc; not reset.
  - Read of the same address in the same cycle returns old data.
- G_FWFT=1:
  - data_o = mem[rd_ptr]; valid_o = !empty_o.
  - data_o is don't-care while empty_o=1.
- G_FWFT=0:
  - On pull_acc, data_o <= mem[rd_ptr]; valid_o <= pull_acc, i.e. valid_o is a one-cycle pulse per accepted pull.
  - data_o holds its value otherwise.
- clr_i and rst_i take priority over push/pull in the same cycle; requests in that cycle are dropped and no error flag is set.

## Timing
- Reset values:
  - level_o=0, empty_o=1, full_o=0, afull_o=0, aempty_o=1, ovf_o=0, udf_o=0, valid_o=0.
  - data_o=0 when G_FWFT=0.
- Write to visible data:
  - G_FWFT=1: a push into an empty FIFO in cycle N gives empty_o=0, valid_o=1 and data_o = written word in cycle N+1.
  - G_FWFT=0: a pull_acc in cycle N gives valid_o=1 with data in cycle N+1.
- Flags update the cycle after the causing push/pull edge; there is no combinational path from push_i/pull_i to any status flag.
- Throughput: one push and one pull per cycle sustained, including at full and at empty after the first word.

## Structure
- Shared package fifo_pkg:
  - function clog2.
  - Parameter-legality checks (power-of-two depth, threshold ranges), enforced via elaboration-time assertion.
- Sub-module fifo_ram:
  - Simple dual-port array, synchronous write.
  - Parameter selects async read (FWFT) or registered read.
- Control logic (acceptance, pointers, level, flags) stays in sync_fifo_lvl.

## Test plan
- Reset then push 0x11..0x1F, 0x20 (16 words, G_DEPTH=16) -> level_o steps 1..16; full_o=1 after the 16th push; afull_o=1 from level 14.
- With the FIFO full, push 0xDEAD with no pull -> ovf_o=1, level_o stays 16, 0xDEAD is never read back.
- With the FIFO full, push 0xBEEF with pull in the same cycle -> level_o stays 16, ovf_o=0; 0xBEEF is read 16th in order.
- With the FIFO empty, pull with push 0x5A in the same cycle -> udf_o=1, level_o=1; next read returns 0x5A.
- Run G_FWFT=0 and G_FWFT=1 builds with the same stream 0..99 under random push/pull -> output order matches a scoreboard; registered build shows data one cycle after each accepted pull.
- Fill to level 7, assert clr_i together with push -> next cycle level_o=0, empty_o=1, ovf_o=udf_o=0; pointers restart at 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the level-reporting FIFO: width calculation and
// parameter-legality check used at elaboration.
package fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int afull, input int aempty,
                                   input int fwft);
    return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1) &&
           ((fwft == 0) || (fwft == 1));
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, async (show-ahead) or
// registered read selected by REG_RD.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int W      = 32,
  parameter int DEPTH  = 16,
  parameter bit REG_RD = 1'b0,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge clk_i)
    if (we) mem[waddr] <= wdata;

  if (REG_RD) begin : g_reg
    // Same-address write/read in one cycle returns the old word.
    always_ff @(posedge clk_i)
      if (rst_i)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
  end else begin : g_async
    logic unused;
    assign unused = rst_i ^ re;
    assign rdata  = mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, sticky
// overflow/underflow flags and show-ahead or registered read.
module sync_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int G_WIDTH  = 32,
  parameter int G_DEPTH  = 16,
  parameter int G_AFULL  = G_DEPTH - 2,
  parameter int G_AEMPTY = 1,
  parameter int G_FWFT   = 1,
  parameter int AW       = clog2(G_DEPTH),
  parameter int LW       = clog2(G_DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic [G_WIDTH-1:0] data_i,
  input  logic               push_i,
  input  logic               pull_i,
  output logic [G_WIDTH-1:0] data_o,
  output logic               valid_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               afull_o,
  output logic               aempty_o,
  output logic [LW-1:0]      level_o,
  output logic               ovf_o,
  output logic               udf_o
);

  if (!params_ok(G_WIDTH, G_DEPTH, G_AFULL, G_AEMPTY, G_FWFT)) begin : g_bad_params
    $error("sync_fifo_lvl: illegal parameter set");
  end

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_acc, pull_acc, flush;

  assign flush    = rst_i | clr_i;
  assign pull_acc = pull_i & ~empty_o;
  // A pull from a full FIFO frees the slot the concurrent push lands in.
  assign push_acc = push_i & (~full_o | pull_acc);

  assign empty_o  = (level_o == '0);
  assign full_o   = (level_o == LW'(G_DEPTH));
  assign afull_o  = (level_o >= LW'(G_AFULL));
  assign aempty_o = (level_o <= LW'(G_AEMPTY));

  always_ff @(posedge clk_i)
    if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
      ovf_o   <= 1'b0;
      udf_o   <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pull_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pull_acc})
        2'b10:   level_o <= level_o + LW'(1);
        2'b01:   level_o <= level_o - LW'(1);
        default: level_o <= level_o;
      endcase
      if (push_i & ~push_acc) ovf_o <= 1'b1;
      if (pull_i & ~pull_acc) udf_o <= 1'b1;
    end

  fifo_ram #(
    .W      (G_WIDTH),
    .DEPTH  (G_DEPTH),
    .REG_RD (G_FWFT == 0),
    .AW     (AW)
  ) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (push_acc & ~flush),
    .waddr (wr_ptr),
    .wdata (data_i),
    .re    (pull_acc & ~flush),
    .raddr (rd_ptr),
    .rdata (data_o)
  );

  if (G_FWFT != 0) begin : g_fwft
    assign valid_o = ~empty_o;
  end else begin : g_regrd
    logic vld_q;
    always_ff @(posedge clk_i)
      if (flush) vld_q <= 1'b0;
      else       vld_q <= pull_acc;
    assign valid_o = vld_q;
  end

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Drives a show-ahead and a registered-read FIFO with identical traffic and
// scores both against a queue-based reference.
module tb_sync_fifo_lvl;
  localparam int W = 32, D = 16, AF = 14, AE = 1, LW = 5;

  logic          clk_i = 1'b0, rst_i = 1'b1, clr_i = 1'b0;
  logic          push_i = 1'b0, pull_i = 1'b0;
  logic [W-1:0]  data_i = '0;

  logic [W-1:0]  f_data, r_data;
  logic          f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic          r_valid, r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;
  logic [LW-1:0] f_level, r_level;

  sync_fifo_lvl #(.G_WIDTH(W), .G_DEPTH(D), .G_AFULL(AF), .G_AEMPTY(AE), .G_FWFT(1)) u_fwft (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .data_i(data_i), .push_i(push_i),
    .pull_i(pull_i), .data_o(f_data), .valid_o(f_valid), .full_o(f_full),
    .empty_o(f_empty), .afull_o(f_afull), .aempty_o(f_aempty), .level_o(f_level),
    .ovf_o(f_ovf), .udf_o(f_udf));

  sync_fifo_lvl #(.G_WIDTH(W), .G_DEPTH(D), .G_AFULL(AF), .G_AEMPTY(AE), .G_FWFT(0)) u_reg (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .data_i(data_i), .push_i(push_i),
    .pull_i(pull_i), .data_o(r_data), .valid_o(r_valid), .full_o(r_full),
    .empty_o(r_empty), .afull_o(r_afull), .aempty_o(r_aempty), .level_o(r_level),
    .ovf_o(r_ovf), .udf_o(r_udf));

  always #5 clk_i = ~clk_i;

  int n_pass = 0, n_chk = 0;
  logic [W-1:0] mq[$], exp_f[$], exp_r[$];
  bit m_ovf, m_udf, m_rvld, last_wa;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: what the next clock edge does to the FIFO contents.
  task automatic model_apply(input bit p, input logic [W-1:0] d, input bit q, input bit c);
    bit pa, wa;
    if (c) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_rvld = 0; last_wa = 0;
    end else begin
      pa = q && (mq.size() > 0);
      wa = p && ((mq.size() < D) || pa);
      if (pa) begin
        exp_f.push_back(mq[0]);
        exp_r.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (wa) mq.push_back(d);
      if (p && !wa) m_ovf = 1;
      if (q && !pa) m_udf = 1;
      m_rvld  = pa;
      last_wa = wa;
    end
  endtask

  task automatic check_inst(input string t, input int lvl, input bit e, input bit f,
                            input bit af, input bit ae, input bit o, input bit u);
    int n;
    n = mq.size();
    chk({t, "_level"},  lvl, n);
    chk({t, "_empty"},  e,   n == 0);
    chk({t, "_full"},   f,   n == D);
    chk({t, "_afull"},  af,  n >= AF);
    chk({t, "_aempty"}, ae,  n <= AE);
    chk({t, "_ovf"},    o,   m_ovf);
    chk({t, "_udf"},    u,   m_udf);
  endtask

  task automatic check_state();
    check_inst("fwft", int'(f_level), f_empty, f_full, f_afull, f_aempty, f_ovf, f_udf);
    check_inst("reg",  int'(r_level), r_empty, r_full, r_afull, r_aempty, r_ovf, r_udf);
    chk("fwft_valid", f_valid, mq.size() > 0);
    chk("reg_valid",  r_valid, m_rvld);
  endtask

  task automatic step(input bit p, input logic [W-1:0] d, input bit q, input bit c);
    push_i = p; data_i = d; pull_i = q; clr_i = c;
    model_apply(p, d, q, c);
    @(posedge clk_i); #1;
    push_i = 0; pull_i = 0; clr_i = 0;
    check_state();
  endtask

  // Data monitor: show-ahead word is consumed at the pull edge, registered
  // word appears as a valid pulse the cycle after.
  always @(negedge clk_i) begin
    if (pull_i && f_valid && !clr_i && !rst_i) begin
      if (exp_f.size() == 0) chk("fwft_extra_read", 1, 0);
      else chk("fwft_data", f_data, exp_f.pop_front());
    end
    if (r_valid) begin
      if (exp_r.size() == 0) chk("reg_extra_read", 1, 0);
      else chk("reg_data", r_data, exp_r.pop_front());
    end
  end

  initial begin
    int nv;
    mq.delete(); m_ovf = 0; m_udf = 0; m_rvld = 0;
    rst_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    check_state();
    chk("reg_data_rst", r_data, 0);
    rst_i = 0;

    for (int i = 0; i < 16; i++) step(1, 32'h11 + i, 0, 0);
    step(1, 32'hBEEF, 1, 0);      // full + pull: push accepted, no overflow
    step(1, 32'hDEAD, 0, 0);      // full, no pull: overflow, word dropped
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    step(0, 0, 0, 1);
    step(1, 32'h5A, 1, 0);        // empty: pull rejected, push accepted
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    for (int i = 0; i < 7; i++) step(1, 32'h70 + i, 0, 0);
    step(1, 32'hFF, 1, 1);        // flush wins over push/pull
    step(1, 32'h77, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);

    nv = 0;
    for (int cyc = 0; cyc < 4000 && (nv < 100 || mq.size() > 0); cyc++) begin
      step((nv < 100) && ($urandom % 4 != 0), 32'(nv), ($urandom % 3 != 0), 0);
      if (last_wa) nv++;
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("stream_sent", nv, 100);
    chk("model_drained", mq.size(), 0);
    chk("fwft_sb_empty", exp_f.size(), 0);
    chk("reg_sb_empty", exp_r.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
